// File: rtl/bpu_pkg.sv
// Shared definitions for the tournament branch predictor.
// Contents: MIPS opcode and REGIMM rt codes, the 2-bit counter type and its reset value,
//           and the saturating counter step helpers.
package bpu_pkg;

    // 2-bit saturating counter; MSB set means "taken" (or "gshare" in the chooser).
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_NT = 2'b01;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Step a counter one position toward the given direction.
    function automatic ctr_t sat_move(input ctr_t c, input logic up);
        return up ? sat_inc(c) : sat_dec(c);
    endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Table of 2-bit saturating counters with one combinational read port and one
// clocked read-modify-write update port that steps an entry toward wr_up.
// Ports: clk, rst (async active-low, all entries -> weak NT), rd_idx/rd_ctr, wr_en/wr_idx/wr_up.
module sat_ctr_table
    import bpu_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);

    localparam int DEPTH = 2 ** IDX_W;

    ctr_t tbl [DEPTH];

    // Read sees pre-edge contents; a same-cycle write to rd_idx is not forwarded.
    assign rd_ctr = tbl[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= sat_move(tbl[wr_idx], wr_up);
        end
    end

endmodule

// File: rtl/bpu_tournament.sv
// Tournament branch predictor: gshare + bimodal, per-PC chooser, speculative GHR with
// mispredict recovery. Predicts combinationally in IF, trained from ID resolution.
// Ports: clk/rst (async active-low), stall, if_pc/if_inst -> pdt_*; upd_* training inputs.
module bpu_tournament
    import bpu_pkg::*;
#(
    parameter int GHR_W     = 10,
    parameter int LOC_IDX_W = 10,
    parameter int CHO_IDX_W = 10,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [31:0]       if_inst,
    output logic              pdt_taken,
    output logic [ADDR_W-1:0] pdt_pc,
    output logic              pdt_which,
    output logic [GHR_W-1:0]  pdt_history,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    input  logic              upd_which,
    input  logic              upd_g_pred,
    input  logic              upd_l_pred,
    input  logic [GHR_W-1:0]  upd_history
);

    logic [GHR_W-1:0]  ghr;

    // ---------------------------------------------------------------- decode
    logic [5:0]        opcode;
    logic [4:0]        rt;
    logic              is_regimm_br;
    logic              is_cond;
    logic              is_jmp;

    assign opcode = if_inst[31:26];
    assign rt     = if_inst[20:16];

    assign is_regimm_br = (opcode == OP_REGIMM) &&
                          ((rt == RT_BLTZ)   || (rt == RT_BGEZ) ||
                           (rt == RT_BLTZAL) || (rt == RT_BGEZAL));
    assign is_cond = (opcode == OP_BEQ)  || (opcode == OP_BNE)  ||
                     (opcode == OP_BLEZ) || (opcode == OP_BGTZ) || is_regimm_br;
    // JR/JALR are register-indirect and are left to the pipeline.
    assign is_jmp  = (opcode == OP_J) || (opcode == OP_JAL);

    // ---------------------------------------------------------------- targets
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jmp_tgt;

    assign pc4     = if_pc + ADDR_W'(4);
    assign br_off  = {{(ADDR_W-18){if_inst[15]}}, if_inst[15:0], 2'b00};
    assign br_tgt  = pc4 + br_off;
    assign jmp_tgt = {pc4[ADDR_W-1:28], if_inst[25:0], 2'b00};

    // ---------------------------------------------------------------- tables
    logic [GHR_W-1:0]     g_rd_idx;
    logic [GHR_W-1:0]     g_wr_idx;
    logic [LOC_IDX_W-1:0] l_rd_idx;
    logic [LOC_IDX_W-1:0] l_wr_idx;
    logic [CHO_IDX_W-1:0] c_rd_idx;
    logic [CHO_IDX_W-1:0] c_wr_idx;
    logic [1:0]           g_ctr;
    logic [1:0]           l_ctr;
    logic [1:0]           c_ctr;
    logic                 c_wr_en;
    logic                 c_wr_up;

    assign g_rd_idx = ghr ^ if_pc[GHR_W+1:2];
    assign l_rd_idx = if_pc[LOC_IDX_W+1:2];
    assign c_rd_idx = if_pc[CHO_IDX_W+1:2];

    // Training uses the history snapshot that made the prediction, not the live GHR.
    assign g_wr_idx = upd_history ^ upd_pc[GHR_W+1:2];
    assign l_wr_idx = upd_pc[LOC_IDX_W+1:2];
    assign c_wr_idx = upd_pc[CHO_IDX_W+1:2];

    // Chooser only learns when the two components disagreed; then it steps toward
    // whichever one matched the outcome.
    assign c_wr_en = upd_valid && (upd_g_pred != upd_l_pred);
    assign c_wr_up = (upd_g_pred == upd_taken);

    sat_ctr_table #(.IDX_W(GHR_W)) u_gshare (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (g_rd_idx),
        .rd_ctr (g_ctr),
        .wr_en  (upd_valid),
        .wr_idx (g_wr_idx),
        .wr_up  (upd_taken)
    );

    sat_ctr_table #(.IDX_W(LOC_IDX_W)) u_bimodal (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (l_rd_idx),
        .rd_ctr (l_ctr),
        .wr_en  (upd_valid),
        .wr_idx (l_wr_idx),
        .wr_up  (upd_taken)
    );

    sat_ctr_table #(.IDX_W(CHO_IDX_W)) u_chooser (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (c_rd_idx),
        .rd_ctr (c_ctr),
        .wr_en  (c_wr_en),
        .wr_idx (c_wr_idx),
        .wr_up  (c_wr_up)
    );

    // ---------------------------------------------------------------- prediction
    logic sel_taken;
    logic cond_taken;

    assign pdt_which   = c_ctr[1];
    assign sel_taken   = pdt_which ? g_ctr[1] : l_ctr[1];
    assign cond_taken  = is_cond && sel_taken;
    assign pdt_taken   = is_jmp || cond_taken;
    assign pdt_pc      = is_jmp ? jmp_tgt : (cond_taken ? br_tgt : pc4);
    assign pdt_history = ghr;

    // ---------------------------------------------------------------- GHR
    // Recovery beats the speculative shift: the instruction in IF during a
    // mispredict is on the wrong path, so its shift must not survive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispred) begin
            ghr <= {upd_history[GHR_W-2:0], upd_taken};
        end else if (is_cond && !stall) begin
            ghr <= {ghr[GHR_W-2:0], pdt_taken};
        end
    end

    // upd_which travels with the branch for the pipeline's benefit; the chooser
    // update is fully determined by the two component predictions.
    logic unused_bits;
    assign unused_bits = ^{upd_which, upd_pc};

endmodule

// File: tb/tb_bpu_tournament.sv
module tb_bpu_tournament;

    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] I_BEQ4   = 32'h1000_0004; // BEQ imm=0x0004
    localparam logic [31:0] I_BNE_M1 = 32'h1400_FFFF; // BNE imm=0xFFFF
    localparam logic [31:0] I_J40    = 32'h0800_0040; // J idx=0x0000040

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        pdt_taken;
    logic [31:0] pdt_pc;
    logic        pdt_which;
    logic [9:0]  pdt_history;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispred;
    logic        upd_which;
    logic        upd_g_pred;
    logic        upd_l_pred;
    logic [9:0]  upd_history;

    bpu_tournament #(
        .GHR_W(10), .LOC_IDX_W(10), .CHO_IDX_W(10), .ADDR_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .pdt_taken   (pdt_taken),
        .pdt_pc      (pdt_pc),
        .pdt_which   (pdt_which),
        .pdt_history (pdt_history),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .upd_which   (upd_which),
        .upd_g_pred  (upd_g_pred),
        .upd_l_pred  (upd_l_pred),
        .upd_history (upd_history)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] pc;
        logic        which;
        logic [9:0]  hist;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: outputs are combinational, so every negedge is a sample point;
    // any expectation queued during this cycle is compared here.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (pdt_taken !== e.taken || pdt_pc !== e.pc ||
                pdt_which !== e.which || pdt_history !== e.hist) begin
                failures++;
                $display("FAIL %s: got taken=%0b pc=%h which=%0b hist=%h, want taken=%0b pc=%h which=%0b hist=%h",
                         e.name, pdt_taken, pdt_pc, pdt_which, pdt_history,
                         e.taken, e.pc, e.which, e.hist);
            end
        end
    end

    task automatic expect_out(input string name, input logic t, input logic [31:0] pc,
                              input logic w, input logic [9:0] h);
        exp_t e;
        e.name = name; e.taken = t; e.pc = pc; e.which = w; e.hist = h;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input logic stl);
        if_pc = pc; if_inst = inst; stall = stl;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t, input logic mis,
                       input logic g, input logic l, input logic [9:0] h);
        upd_valid = v; upd_pc = pc; upd_taken = t; upd_mispred = mis;
        upd_g_pred = g; upd_l_pred = l; upd_history = h; upd_which = g;
    endtask

    initial begin
        rst = 1'b0;
        fetch(32'h100, I_BEQ4, 1'b0);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        #1;
        // 1. reset state
        expect_out("reset_beq", 1'b0, 32'h104, 1'b0, 10'h000);

        next_cycle();
        fetch(32'h100, I_NOP, 1'b0);
        rst = 1'b1;

        // 2. J always taken, GHR unchanged
        next_cycle();
        fetch(32'h0040_0000, I_J40, 1'b0);
        expect_out("jump_c1", 1'b1, 32'h100, 1'b0, 10'h000);
        next_cycle();
        expect_out("jump_c2", 1'b1, 32'h100, 1'b0, 10'h000);

        // 3. bimodal training at 0x200, stalled fetch of the same branch
        next_cycle();
        fetch(32'h200, I_BNE_M1, 1'b1);
        upd(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("bim_u1_no_fwd", 1'b0, 32'h204, 1'b0, 10'h000);
        next_cycle();
        expect_out("bim_u2_ctr10", 1'b1, 32'h200, 1'b0, 10'h000);
        next_cycle();
        expect_out("bim_u3_ctr11", 1'b1, 32'h200, 1'b0, 10'h000);
        next_cycle();
        upd(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("bim_sat_hold11", 1'b1, 32'h200, 1'b0, 10'h000);
        next_cycle();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("bim_ctr10_after_nt", 1'b1, 32'h200, 1'b0, 10'h000);

        // speculative shift of a predicted-taken cond branch
        next_cycle();
        fetch(32'h200, I_BNE_M1, 1'b0);
        expect_out("spec_shift_pre", 1'b1, 32'h200, 1'b0, 10'h000);

        // 4. recovery beats speculative shift
        next_cycle();
        fetch(32'h100, I_BEQ4, 1'b0);
        upd(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 10'h155);
        expect_out("ghr_after_shift", 1'b0, 32'h104, 1'b0, 10'h001);
        next_cycle();
        fetch(32'h100, I_NOP, 1'b0);
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("ghr_recovered", 1'b0, 32'h104, 1'b0, 10'h2AA);

        // 5. chooser training at 0x300
        next_cycle();
        fetch(32'h300, I_NOP, 1'b0);
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0);
        expect_out("cho_c1_01", 1'b0, 32'h304, 1'b0, 10'h2AA);
        next_cycle();
        expect_out("cho_c2_10", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        expect_out("cho_c3_11", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("cho_sat_11", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0);
        expect_out("cho_dec1_pre11", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 10'h0);
        expect_out("cho_agree_pre10", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0);
        expect_out("cho_dec2_pre10", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("cho_back_01", 1'b0, 32'h304, 1'b0, 10'h2AA);

        // gshare path: train gshare[0x2AA^0xC0] and chooser to 11
        next_cycle();
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA);
        expect_out("gs_prep1", 1'b0, 32'h304, 1'b0, 10'h2AA);
        next_cycle();
        expect_out("gs_prep2", 1'b0, 32'h304, 1'b1, 10'h2AA);
        next_cycle();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        fetch(32'h300, I_BEQ4, 1'b1);
        expect_out("gs_predict_taken", 1'b1, 32'h314, 1'b1, 10'h2AA);

        // 6. async reset mid-update
        next_cycle();
        upd(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 10'h2AA);
        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst_now", 1'b0, 32'h304, 1'b0, 10'h000);
        next_cycle();
        expect_out("rst_held_upd_ignored", 1'b0, 32'h304, 1'b0, 10'h000);
        next_cycle();
        rst = 1'b1;
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        fetch(32'h200, I_NOP, 1'b1);
        next_cycle();
        fetch(32'h200, I_BNE_M1, 1'b1);
        upd(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("post_rst_first_upd", 1'b0, 32'h204, 1'b0, 10'h000);
        next_cycle();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
        expect_out("post_rst_ctr10", 1'b1, 32'h200, 1'b0, 10'h000);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
